// File: rtl/vga_tilt_ball.sv
// VGA raster generator drawing a ball whose motion is integrated from accelerometer tilt.
// Optional macro CENTER_MARK_EN overlays a 1-pixel black crosshair through the screen centre.
module vga_tilt_ball #(
  parameter int          H_ACT            = 640,
  parameter int          H_FRONT          = 16,
  parameter int          H_SYNC           = 96,
  parameter int          H_BACK           = 48,
  parameter int          V_ACT            = 480,
  parameter int          V_FRONT          = 10,
  parameter int          V_SYNC           = 2,
  parameter int          V_BACK           = 33,
  parameter int          SYNC_ACTIVE_HIGH = 1,
  parameter int          RADIUS           = 50,
  parameter int          ACC_W            = 10,
  parameter int          ACC_SHIFT        = 4,
  parameter int          VMAX             = 16,
  parameter logic [11:0] BALL_RGB         = 12'hF52,
  parameter logic [11:0] BG_RGB           = 12'hFFF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [ACC_W-1:0] x_acc,
  input  logic signed [ACC_W-1:0] y_acc,
  input  logic                    acc_valid,
  output logic                    o_hsync,
  output logic                    o_vsync,
  output logic [3:0]              o_red,
  output logic [3:0]              o_green,
  output logic [3:0]              o_blue,
  output logic                    o_frame_tick,
  output logic                    o_bounce
);

  localparam int H_TOTAL   = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int V_TOTAL   = V_SYNC + V_BACK + V_ACT + V_FRONT;
  localparam int H_START   = H_SYNC + H_BACK;
  localparam int V_START   = V_SYNC + V_BACK;
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
  localparam logic [23:0]        R_SQ   = 24'(RADIUS * RADIUS);
  localparam logic signed [12:0] VMAX_S = 13'(VMAX);
  localparam logic signed [12:0] LO_S   = 13'(RADIUS);
  localparam logic signed [12:0] HI_X_S = 13'(H_ACT - 1 - RADIUS);
  localparam logic signed [12:0] HI_Y_S = 13'(V_ACT - 1 - RADIUS);

  // One axis of the per-frame update; result packs {bounce, vel[7:0], pos[11:0]}.
  function automatic logic [20:0] axis_step(input logic signed [11:0]      pos,
                                            input logic signed [7:0]       vel,
                                            input logic signed [ACC_W-1:0] acc,
                                            input logic signed [12:0]      hi_lim);
    logic signed [12:0] a_s;
    logic signed [12:0] v_s;
    logic signed [12:0] p_s;
    logic [20:0]        res;
    a_s = acc;
    a_s = a_s >>> ACC_SHIFT;
    v_s = vel + a_s;
    if (v_s > VMAX_S) begin
      v_s = VMAX_S;
    end else if (v_s < -VMAX_S) begin
      v_s = -VMAX_S;
    end else begin
      v_s = v_s;
    end
    p_s = pos + v_s;
    if (p_s < LO_S) begin
      res = {1'b1, 8'(-v_s), 12'(LO_S)};
    end else if (p_s > hi_lim) begin
      res = {1'b1, 8'(-v_s), 12'(hi_lim)};
    end else begin
      res = {1'b0, 8'(v_s), 12'(p_s)};
    end
    return res;
  endfunction

  logic [11:0]              h_cnt_r, v_cnt_r;
  logic                     h_last_s, v_last_s, tick_s;
  logic signed [ACC_W-1:0]  acc_x_r, acc_y_r;
  logic signed [11:0]       pos_x_r, pos_y_r;
  logic signed [7:0]        vel_x_r, vel_y_r;
  logic [20:0]              step_x_s, step_y_s;
  logic                     bounce_s;

  assign h_last_s = (h_cnt_r == 12'(H_TOTAL - 1));
  assign v_last_s = (v_cnt_r == 12'(V_TOTAL - 1));
  assign tick_s   = h_last_s & v_last_s;

  // Raster counters: sync, back porch, active, front porch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r <= 12'd0;
      v_cnt_r <= 12'd0;
    end else if (h_last_s) begin
      h_cnt_r <= 12'd0;
      v_cnt_r <= v_last_s ? 12'd0 : v_cnt_r + 12'd1;
    end else begin
      h_cnt_r <= h_cnt_r + 12'd1;
    end
  end

  // Accelerometer holding registers; a strobe on the tick cycle serves the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_x_r <= '0;
      acc_y_r <= '0;
    end else if (acc_valid) begin
      acc_x_r <= x_acc;
      acc_y_r <= y_acc;
    end else begin
      acc_x_r <= acc_x_r;
      acc_y_r <= acc_y_r;
    end
  end

  assign step_x_s = axis_step(pos_x_r, vel_x_r, acc_x_r, HI_X_S);
  assign step_y_s = axis_step(pos_y_r, vel_y_r, acc_y_r, HI_Y_S);
  assign bounce_s = step_x_s[20] | step_y_s[20];

  // Ball state update once per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_r <= 12'(H_ACT / 2);
      pos_y_r <= 12'(V_ACT / 2);
      vel_x_r <= 8'sd0;
      vel_y_r <= 8'sd0;
    end else if (tick_s) begin
      pos_x_r <= step_x_s[11:0];
      pos_y_r <= step_y_s[11:0];
      vel_x_r <= step_x_s[19:12];
      vel_y_r <= step_y_s[19:12];
    end else begin
      pos_x_r <= pos_x_r;
      pos_y_r <= pos_y_r;
      vel_x_r <= vel_x_r;
      vel_y_r <= vel_y_r;
    end
  end

  logic [11:0]        px_s, py_s;
  logic               active_s;
  logic signed [11:0] dx_r, dy_r;
  logic               hs1_r, vs1_r, act1_r, tick1_r, bnc1_r;
  logic signed [23:0] dx_e_s, dy_e_s, dx_sq_s, dy_sq_s;
  logic [23:0]        dist_s;
  logic               inside_r, hs2_r, vs2_r, act2_r, tick2_r, bnc2_r;
  logic [11:0]        pix_rgb_s;
`ifdef CENTER_MARK_EN
  logic               ch1_r, ch2_r;
`endif

  assign px_s     = h_cnt_r - 12'(H_START);
  assign py_s     = v_cnt_r - 12'(V_START);
  assign active_s = (h_cnt_r >= 12'(H_START)) && (h_cnt_r < 12'(H_START + H_ACT)) &&
                    (v_cnt_r >= 12'(V_START)) && (v_cnt_r < 12'(V_START + V_ACT));

  // Stage 1: offsets from ball centre plus delayed timing flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_r    <= 12'sd0;
      dy_r    <= 12'sd0;
      hs1_r   <= 1'b0;
      vs1_r   <= 1'b0;
      act1_r  <= 1'b0;
      tick1_r <= 1'b0;
      bnc1_r  <= 1'b0;
    end else begin
      dx_r    <= $signed(px_s) - pos_x_r;
      dy_r    <= $signed(py_s) - pos_y_r;
      hs1_r   <= (h_cnt_r < 12'(H_SYNC));
      vs1_r   <= (v_cnt_r < 12'(V_SYNC));
      act1_r  <= active_s;
      tick1_r <= tick_s;
      bnc1_r  <= tick_s & bounce_s;
    end
  end

  assign dx_e_s  = dx_r;
  assign dy_e_s  = dy_r;
  assign dx_sq_s = dx_e_s * dx_e_s;
  assign dy_sq_s = dy_e_s * dy_e_s;
  assign dist_s  = $unsigned(dx_sq_s) + $unsigned(dy_sq_s);

  // Stage 2: inside-circle test.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inside_r <= 1'b0;
      hs2_r    <= 1'b0;
      vs2_r    <= 1'b0;
      act2_r   <= 1'b0;
      tick2_r  <= 1'b0;
      bnc2_r   <= 1'b0;
    end else begin
      inside_r <= (dist_s <= R_SQ);
      hs2_r    <= hs1_r;
      vs2_r    <= vs1_r;
      act2_r   <= act1_r;
      tick2_r  <= tick1_r;
      bnc2_r   <= bnc1_r;
    end
  end

`ifdef CENTER_MARK_EN
  // Crosshair flag travels alongside stages 1 and 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch1_r <= 1'b0;
      ch2_r <= 1'b0;
    end else begin
      ch1_r <= active_s && ((px_s == 12'(H_ACT / 2)) || (py_s == 12'(V_ACT / 2)));
      ch2_r <= ch1_r;
    end
  end
`endif

  // Colour select with blanking forced to black.
  always_comb begin
    pix_rgb_s = 12'h000;
    if (!act2_r) begin
      pix_rgb_s = 12'h000;
`ifdef CENTER_MARK_EN
    end else if (ch2_r) begin
      pix_rgb_s = 12'h000;
`endif
    end else if (inside_r) begin
      pix_rgb_s = BALL_RGB;
    end else begin
      pix_rgb_s = BG_RGB;
    end
  end

  // Stage 3: registered pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_hsync      <= SYNC_IDLE;
      o_vsync      <= SYNC_IDLE;
      o_red        <= 4'h0;
      o_green      <= 4'h0;
      o_blue       <= 4'h0;
      o_frame_tick <= 1'b0;
      o_bounce     <= 1'b0;
    end else begin
      o_hsync      <= hs2_r ^ SYNC_IDLE;
      o_vsync      <= vs2_r ^ SYNC_IDLE;
      o_red        <= pix_rgb_s[11:8];
      o_green      <= pix_rgb_s[7:4];
      o_blue       <= pix_rgb_s[3:0];
      o_frame_tick <= tick2_r;
      o_bounce     <= bnc2_r;
    end
  end

endmodule

// File: tb/tb_vga_tilt_ball.sv
// Self-checking bench for vga_tilt_ball on a shrunken raster; a frame-level model predicts every output cycle.
module tb_vga_tilt_ball;
  localparam int HA = 40, HF = 4, HS = 8, HB = 4;
  localparam int VA = 30, VF = 2, VS = 2, VB = 3;
  localparam int R = 5, VM = 6, SH = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int NF = 64;
  localparam logic [11:0] BALL = 12'hF52;
  localparam logic [11:0] BG   = 12'hFFF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              acc_valid = 1'b0;
  logic signed [9:0] x_acc = 10'sd0;
  logic signed [9:0] y_acc = 10'sd0;
  logic              o_hsync, o_vsync, o_frame_tick, o_bounce;
  logic [3:0]        o_red, o_green, o_blue;
  logic [15:0]       obs, exp_v;

  int checks = 0;
  int failures = 0;
  int k;
  int mx, my, mvx, mvy, hax, hay;
  int hist_x[NF];
  int hist_y[NF];
  bit bnc[NF];

  always #20 clk = ~clk;

  assign obs = {o_frame_tick, o_bounce, o_hsync, o_vsync, o_red, o_green, o_blue};

  vga_tilt_ball #(
    .H_ACT(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACT(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_HIGH(1), .RADIUS(R), .ACC_W(10), .ACC_SHIFT(SH), .VMAX(VM),
    .BALL_RGB(BALL), .BG_RGB(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x_acc(x_acc), .y_acc(y_acc), .acc_valid(acc_valid),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_frame_tick(o_frame_tick), .o_bounce(o_bounce)
  );

  task automatic model_reset();
    k = 0; mx = HA / 2; my = VA / 2; mvx = 0; mvy = 0; hax = 0; hay = 0;
    for (int i = 0; i < NF; i++) begin
      hist_x[i] = 0; hist_y[i] = 0; bnc[i] = 1'b0;
    end
    hist_x[0] = mx; hist_y[0] = my;
  endtask

  task automatic axis(input int p, input int v, input int a, input int hi,
                      output int po, output int vo, output int b);
    int nv, np;
    nv = v + (a >>> SH);
    if (nv > VM) nv = VM;
    if (nv < -VM) nv = -VM;
    np = p + nv;
    b = 0;
    if (np < R) begin po = R; vo = -nv; b = 1; end
    else if (np > hi) begin po = hi; vo = -nv; b = 1; end
    else begin po = np; vo = nv; end
  endtask

  // One clock: drive inputs, advance the model at the edge, return at the following falling edge.
  task automatic step(input bit v, input int xa, input int ya);
    int bx, by, nt;
    acc_valid = v; x_acc = 10'(xa); y_acc = 10'(ya);
    @(posedge clk);
    if (rst_n) begin
      k++;
      if (k % FRAME == 0) begin
        axis(mx, mvx, hax, HA - 1 - R, mx, mvx, bx);
        axis(my, mvy, hay, VA - 1 - R, my, mvy, by);
        nt = k / FRAME;
        if (nt < NF) begin
          hist_x[nt] = mx; hist_y[nt] = my; bnc[nt] = (bx | by) != 0;
        end
      end
      if (v) begin hax = xa; hay = ya; end
    end
    @(negedge clk);
    acc_valid = 1'b0;
  endtask

  // Expected {tick, bounce, hsync, vsync, rgb} after kk clocks since reset release.
  function automatic logic [15:0] expect_at(input int kk);
    int s, f, w, h, v, px, py, dx, dy;
    logic hs, vs, act, tk, bn;
    logic [11:0] rgb;
    if (kk < 3) return 16'h0000;
    s = kk - 3; f = s / FRAME; w = s % FRAME; h = w % HT; v = w / HT;
    if (f > NF - 2) f = NF - 2;
    hs = (h < HS); vs = (v < VS);
    act = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    px = h - HS - HB; py = v - VS - VB;
    dx = px - hist_x[f]; dy = py - hist_y[f];
    if (!act) rgb = 12'h000;
    else if (dx * dx + dy * dy <= R * R) rgb = BALL;
    else rgb = BG;
    tk = (w == FRAME - 1);
    bn = tk && bnc[f + 1];
    return {tk, bn, hs, vs, rgb};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 16'h0000) begin
      failures++; $display("FAIL reset_vals got=%h exp=%h", obs, 16'h0000);
    end
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 3 * HT; i++) begin
      step(1'b0, 0, 0);
      exp_v = expect_at(k); checks++;
      if (obs !== exp_v) begin
        failures++; if (failures <= 20) $display("FAIL reset_run k=%0d got=%h exp=%h", k, obs, exp_v);
      end
      if (k == 2 || k == 3) begin
        checks++;
        if (o_hsync !== (k == 3)) begin
          failures++; $display("FAIL first_hsync k=%0d got=%b exp=%b", k, o_hsync, (k == 3));
        end
      end
    end
  endtask

  task automatic test_static_ball();
    int p0, p1, p2;
    p0 = (15 + VS + VB) * HT + 20 + HS + HB + 3;
    p1 = p0 + 5;
    p2 = p0 + 6;
    while (k < FRAME + 3) begin
      step(1'b0, 0, 0);
      exp_v = expect_at(k); checks++;
      if (obs !== exp_v) begin
        failures++; if (failures <= 20) $display("FAIL static k=%0d got=%h exp=%h", k, obs, exp_v);
      end
      if (k == p0 || k == p1 || k == p2) begin
        checks++;
        if (obs[11:0] !== ((k == p2) ? BG : BALL)) begin
          failures++; $display("FAIL centre_pixel k=%0d got=%h exp=%h", k, obs[11:0], (k == p2) ? BG : BALL);
        end
      end
    end
  endtask

  task automatic test_drift();
    step(1'b1, 64, 0);
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(1'b0, 0, 0);
      exp_v = expect_at(k); checks++;
      if (obs !== exp_v) begin
        failures++; if (failures <= 20) $display("FAIL drift k=%0d got=%h exp=%h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_saturate_bounce();
    step(1'b1, -512, int'($urandom_range(0, 1023)) - 512);
    for (int i = 0; i < 5 * FRAME; i++) begin
      step(1'b0, 0, 0);
      exp_v = expect_at(k); checks++;
      if (obs !== exp_v) begin
        failures++; if (failures <= 20) $display("FAIL saturate k=%0d got=%h exp=%h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_acc_on_tick();
    step(1'b1, 0, 0);
    while ((k + 1) % FRAME != 0) step(1'b0, 0, 0);
    step(1'b1, 64, 0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 0, 0);
      exp_v = expect_at(k); checks++;
      if (obs !== exp_v) begin
        failures++; if (failures <= 20) $display("FAIL acc_on_tick k=%0d got=%h exp=%h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4 * FRAME; i++) begin
      if ($urandom_range(0, 199) == 0)
        step(1'b1, int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512);
      else
        step(1'b0, 0, 0);
      exp_v = expect_at(k); checks++;
      if (obs !== exp_v) begin
        failures++; if (failures <= 20) $display("FAIL random k=%0d got=%h exp=%h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_mid_reset();
    int target;
    target = (VS + VB + 5) * HT + HS + HB + 10;
    for (int i = 0; i < 2 * FRAME && !(k >= 3 && (k - 3) % FRAME == target); i++) step(1'b0, 0, 0);
    checks++;
    if (obs[11:0] === 12'h000) begin
      failures++; $display("FAIL pre_reset_pixel k=%0d got=%h exp=nonzero", k, obs[11:0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 16'h0000) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", obs, 16'h0000);
    end
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < FRAME + 3; i++) begin
      step(1'b0, 0, 0);
      exp_v = expect_at(k); checks++;
      if (obs !== exp_v) begin
        failures++; if (failures <= 20) $display("FAIL post_reset k=%0d got=%h exp=%h", k, obs, exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_static_ball();
    test_drift();
    test_saturate_bounce();
    test_acc_on_tick();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_tilt_ball.md
Name: vga_tilt_ball

Overview:
- Parametrised VGA raster generator that draws a ball whose motion is integrated from accelerometer tilt.
- Position and velocity update once per frame; the ball bounces off the visible-area edges.
- Pixel path is a 3-stage registered pipeline with matched sync delay.
- Sits between the accelerometer reader (SPI front end) and the DE10-LITE VGA DAC pins.

Parameters:
- H_ACT, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACT, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_HIGH, 1, 1 = syncs high while asserted; 0 = active low
- RADIUS, 50, ball radius (pixels)
- ACC_W, 10, accelerometer sample width, two's complement
- ACC_SHIFT, 4, arithmetic right shift applied to acceleration before velocity integration
- VMAX, 16, velocity magnitude limit (pixels/frame)
- BALL_RGB, 12'hF52, ball colour {R,G,B}
- BG_RGB, 12'hFFF, background colour

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst_n  in  1  asynchronous reset, active low
- x_acc  in  ACC_W  signed X acceleration sample
- y_acc  in  ACC_W  signed Y acceleration sample
- acc_valid  in  1  one-cycle strobe; x_acc/y_acc are valid
- o_hsync  out  1  horizontal sync
- o_vsync  out  1  vertical sync
- o_red  out  4  red
- o_green  out  4  green
- o_blue  out  4  blue
- o_frame_tick  out  1  one-cycle pulse at end of frame
- o_bounce  out  1  one-cycle pulse, coincident with o_frame_tick, when any axis bounced this update

Behaviour:
- Reset is asynchronous, active low, on rst_n; all logic is clocked on clk rising edge. Reset may occur mid-frame and takes effect immediately.
- Reset values:
  - h_cnt = 0, v_cnt = 0
  - pos = (H_ACT/2, V_ACT/2), vel = (0,0), latched acc = (0,0)
  - all pipeline stages cleared
  - o_hsync/o_vsync at inactive level; RGB = 0; o_frame_tick = 0; o_bounce = 0
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters; wraps to 0.
  - v_cnt increments only when h_cnt = H_TOTAL-1, and wraps after V_TOTAL-1.
  - Line order: sync, back porch, active, front porch.
  - Active area: H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACT, and the same rule vertically.
  - px = h_cnt-(H_SYNC+H_BACK); py likewise.
  - Raw sync is asserted while h_cnt < H_SYNC (resp. v_cnt < V_SYNC); the output level is set by SYNC_ACTIVE_HIGH.
- Accelerometer latch:
  - On acc_valid, x_acc/y_acc are captured into holding registers.
  - If acc_valid coincides with the frame tick, the tick uses the previously held value; the new sample serves the next frame.
- Frame tick: internal pulse when h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1. o_frame_tick is the same pulse delayed by 3 cycles, aligned to the pipeline.
- Physics, per axis, on the tick, signed arithmetic, 12-bit position, 8-bit velocity:
  - v' = clamp(vel + (acc >>> ACC_SHIFT), -VMAX, +VMAX)
  - p' = pos + v'
  - If p' < RADIUS: pos = RADIUS, vel = -v', bounce.
  - Else if p' > ACT-1-RADIUS: pos = ACT-1-RADIUS, vel = -v', bounce.
  - Else pos = p', vel = v'.
  - A new position is first visible in the frame starting after the tick.
- Pixel pipeline (latency 3 clocks from counter state to pins; hsync, vsync and active delayed identically):
  - S1: dx = px-pos_x, dy = py-pos_y (signed, 12 bits).
  - S2: inside = dx*dx + dy*dy <= RADIUS*RADIUS (unsigned, 24 bits).
  - S3: colour = inside ? BALL_RGB : BG_RGB; RGB forced to 0 when not active.

Optional Feature:
- Macro CENTER_MARK_EN.
- Defined: a 1-pixel crosshair (px = H_ACT/2 or py = V_ACT/2, active area only) is drawn in 12'h000. Stage S3 applies priority crosshair > ball > background. Latency is unchanged.
- Undefined: no crosshair logic is present; output is exactly as above.

Test Plan:
- Reset release, defaults:
  - o_hsync first high at cycle 3 for 96 cycles, period 800.
  - o_vsync high for 2 lines, period 525 lines.
  - RGB = 0 during blanking.
- acc = 0, first frame:
  - pixel (320,240) = BALL_RGB, (370,240) = BALL_RGB, (371,240) = BG_RGB.
  - Each appears 3 clocks after the counter reaches that pixel.
- acc_x = +64 (>>>4 = +4): after tick 1 pos_x = 324; after tick 2, 332; after tick 3, 344.
- acc_x = -512: vel_x saturates at -16 on the first tick. Pos_x reaches 50 and clamps; o_bounce pulses with o_frame_tick; vel_x becomes +16.
- acc_valid asserted on the tick cycle with x_acc = 64 after holding 0: that frame's vel_x is unchanged; the next frame uses +4.
- Assert rst_n low mid-line at h_cnt = 400:
  - counters, position and outputs return immediately to reset values.
  - the first sync after release occurs at cycle 3.
